decoder_arbiter: RTL and testbench

Round-robin scheduler that shares one measurement readout path among NCH quadrature decoder channels. Each decoder raises a one-cycle update strobe with a new direction/period sample. This block holds one pending sample per channel, arbitrates fairly, and presents one sample at a time on a valid/ready stream to the speed-control or host logic. It flags per-channel overruns when a sample is replaced before being read out.

---
 rtl/decoder_arbiter.sv | 117 +++++++++++
 tb/tb_decoder_arbiter.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/decoder_arbiter.sv
// decoder_arbiter: one pending sample slot per quadrature decoder channel, round-robin
// arbitrated onto a single valid/ready readout stream, with sticky per-channel overrun flags.
module decoder_arbiter #(
  parameter  int CHW = 2,
  parameter  int W   = 8,
  localparam int NCH = 2**CHW
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [NCH-1:0]   en,
  input  logic [NCH-1:0]   upd,
  input  logic [NCH*W-1:0] omega_in,
  input  logic [NCH-1:0]   cw_in,
  input  logic [NCH-1:0]   ovf_clr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CHW-1:0]   out_ch,
  output logic [W-1:0]     out_omega,
  output logic             out_cw,
  output logic [NCH-1:0]   ovf
);

  logic [NCH-1:0] r_pend;
  logic [W-1:0]   r_data [NCH];
  logic [NCH-1:0] r_dir;
  logic [CHW-1:0] r_ptr;
  logic [NCH-1:0] r_ovf;

  logic           r_out_valid;
  logic [CHW-1:0] r_out_ch;
  logic [W-1:0]   r_out_omega;
  logic           r_out_cw;

  logic           w_free;
  logic [NCH-1:0] w_cap;
  logic [NCH-1:0] w_elig;
  logic           w_gnt_any;
  logic           w_gnt_valid;
  logic [CHW-1:0] w_gnt_ch;
  logic [CHW-1:0] w_idx;
  logic [NCH-1:0] w_gnt_oh;

  assign w_free = !r_out_valid || out_ready;
  assign w_cap  = upd & en;
  assign w_elig = r_pend & en;

  // Search starts just after the last granted channel and ends on it, so the
  // most recently served channel has the lowest priority.
  always_comb begin
    // NOTE: every combinational output gets a default first so no latch is inferred.
    w_gnt_any = 1'b0;
    w_gnt_ch  = '0;
    w_idx     = '0;
    for (int k = 1; k <= NCH; k++) begin
      w_idx = r_ptr + CHW'(k);
      if (!w_gnt_any && w_elig[w_idx]) begin
        w_gnt_any = 1'b1;
        w_gnt_ch  = w_idx;
      end
    end
  end

  assign w_gnt_valid = w_free && w_gnt_any;
  assign w_gnt_oh    = w_gnt_valid ? ({{(NCH-1){1'b0}}, 1'b1} << w_gnt_ch) : '0;

  // Control state and the output register.
  always_ff @(posedge clock) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values; the granted slot therefore yields its old data
    // even when the same channel re-captures on this edge.
    if (!reset) begin
      r_pend      <= '0;
      r_dir       <= '0;
      r_ptr       <= '1;
      r_ovf       <= '0;
      r_out_valid <= 1'b0;
      r_out_ch    <= '0;
      r_out_omega <= '0;
      r_out_cw    <= 1'b0;
    end else begin
      if (w_free) begin
        if (w_gnt_valid) begin
          r_out_valid <= 1'b1;
          r_out_ch    <= w_gnt_ch;
          r_out_omega <= r_data[w_gnt_ch];
          r_out_cw    <= r_dir[w_gnt_ch];
          r_ptr       <= w_gnt_ch;
        end else begin
          r_out_valid <= 1'b0;
        end
      end
      for (int i = 0; i < NCH; i++) begin
        if (w_cap[i]) r_dir[i] <= cw_in[i];
      end
      // A disabled channel drops its sample; a re-capture keeps the slot pending.
      r_pend <= en & (upd | (r_pend & ~w_gnt_oh));
      // Overrun only when a pending sample is overwritten without being read;
      // a set on the same edge as a clear wins.
      r_ovf  <= (r_ovf & ~ovf_clr) | (w_cap & r_pend & ~w_gnt_oh);
    end
  end

  // NOTE: the sample storage is deliberately not reset; r_pend alone decides
  // whether a slot holds a meaningful value.
  always_ff @(posedge clock) begin
    for (int i = 0; i < NCH; i++) begin
      if (w_cap[i]) r_data[i] <= omega_in[i*W +: W];
    end
  end

  assign out_valid = r_out_valid;
  assign out_ch    = r_out_ch;
  assign out_omega = r_out_omega;
  assign out_cw    = r_out_cw;
  assign ovf       = r_ovf;

endmodule

// File: tb/tb_decoder_arbiter.sv
// Self-checking bench for decoder_arbiter: directed scenarios plus randomized traffic,
// all compared each cycle against a slot/queue-level reference model.
module tb_decoder_arbiter;
  localparam int CHW = 2;
  localparam int W   = 8;
  localparam int NCH = 2**CHW;

  logic             clock = 1'b0;
  logic             reset;
  logic [NCH-1:0]   en;
  logic [NCH-1:0]   upd;
  logic [NCH*W-1:0] omega_in;
  logic [NCH-1:0]   cw_in;
  logic [NCH-1:0]   ovf_clr;
  logic             out_valid;
  logic             out_ready;
  logic [CHW-1:0]   out_ch;
  logic [W-1:0]     out_omega;
  logic             out_cw;
  logic [NCH-1:0]   ovf;

  always #5 clock = ~clock;

  decoder_arbiter #(.CHW(CHW), .W(W)) dut (
    .clock    (clock),
    .reset    (reset),
    .en       (en),
    .upd      (upd),
    .omega_in (omega_in),
    .cw_in    (cw_in),
    .ovf_clr  (ovf_clr),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_ch   (out_ch),
    .out_omega(out_omega),
    .out_cw   (out_cw),
    .ovf      (ovf)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Reference model: one mailbox slot per channel, a last-served index and an output holder.
  bit           m_pend  [NCH];
  logic [W-1:0] m_data  [NCH];
  bit           m_dir   [NCH];
  bit [NCH-1:0] m_ovf;
  int           m_last;
  bit           m_valid;
  int           m_ch;
  logic [W-1:0] m_omega;
  bit           m_cw;

  function automatic void model_edge();
    int  g;
    bit  free;
    bit  lost;
    if (!reset) begin
      for (int i = 0; i < NCH; i++) m_pend[i] = 0;
      m_ovf   = '0;
      m_last  = NCH - 1;
      m_valid = 0;
      m_ch    = 0;
      m_omega = '0;
      m_cw    = 0;
      return;
    end
    free = !m_valid || out_ready;
    g = -1;
    if (free) begin
      for (int k = 1; k <= NCH; k++) begin
        int c;
        c = (m_last + k) % NCH;
        if (g < 0 && m_pend[c] && en[c]) g = c;
      end
      if (g >= 0) begin
        m_valid = 1;
        m_ch    = g;
        m_omega = m_data[g];
        m_cw    = m_dir[g];
        m_last  = g;
      end else begin
        m_valid = 0;
      end
    end
    for (int i = 0; i < NCH; i++) begin
      lost = upd[i] && en[i] && m_pend[i] && (i != g);
      if (!en[i]) begin
        m_pend[i] = 0;
      end else if (upd[i]) begin
        m_pend[i] = 1;
        m_data[i] = omega_in[i*W +: W];
        m_dir[i]  = cw_in[i];
      end else if (i == g) begin
        m_pend[i] = 0;
      end
      if (lost)            m_ovf[i] = 1'b1;
      else if (ovf_clr[i]) m_ovf[i] = 1'b0;
    end
  endfunction

  task automatic cycle(input string tag);
    model_edge();
    @(posedge clock);
    #1;
    check({tag, ".valid"}, out_valid, m_valid);
    check({tag, ".ovf"},   ovf,       m_ovf);
    check({tag, ".ch"},    out_ch,    m_ch);
    check({tag, ".omega"}, out_omega, m_omega);
    check({tag, ".cw"},    out_cw,    m_cw);
  endtask

  task automatic set_omega(input int ch, input logic [W-1:0] v);
    omega_in[ch*W +: W] = v;
  endtask

  initial begin
    reset = 1'b0; en = '1; upd = '0; omega_in = '0; cw_in = '0;
    ovf_clr = '0; out_ready = 1'b0;
    for (int i = 0; i < NCH; i++) begin
      m_data[i] = '0;
      m_dir[i]  = 0;
    end

    // Reset with update strobes asserted.
    upd = 4'hF; omega_in = 32'hA5A5_A5A5; cw_in = 4'hF;
    repeat (3) cycle("rst");
    check("rst_valid", out_valid, 0);
    check("rst_ch",    out_ch,    0);
    check("rst_omega", out_omega, 0);
    check("rst_cw",    out_cw,    0);
    check("rst_ovf",   ovf,       0);
    reset = 1'b1; upd = '0;
    cycle("post_rst");
    check("rst_upd_ignored", out_valid, 0);

    // Simultaneous updates: first grant after reset is channel 0.
    out_ready = 1'b1; upd = 4'hF; cw_in = 4'b0101;
    for (int i = 0; i < NCH; i++) set_omega(i, W'((i + 1) * 16));
    cycle("simul_cap");
    upd = '0;
    for (int k = 0; k < NCH; k++) begin
      cycle("simul");
      check("simul_valid", out_valid, 1);
      check("simul_ch",    out_ch,    k);
      check("simul_omega", out_omega, (k + 1) * 16);
      check("simul_cw",    out_cw,    k % 2 == 0);
    end
    cycle("simul_end");
    check("simul_drain", out_valid, 0);
    check("simul_ovf",   ovf,       0);

    // Single sample: two edges of latency, valid for exactly one cycle.
    upd = 4'b0100; set_omega(2, 8'h37); cw_in = 4'b0100;
    cycle("single_cap");
    check("single_lat", out_valid, 0);
    upd = '0;
    cycle("single");
    check("single_valid", out_valid, 1);
    check("single_ch",    out_ch,    2);
    check("single_omega", out_omega, 8'h37);
    check("single_cw",    out_cw,    1);
    cycle("single_end");
    check("single_once", out_valid, 0);

    // Backpressure and overrun on channel 1.
    out_ready = 1'b0; cw_in = '0;
    upd = 4'b0010; set_omega(1, 8'h10); cycle("bp1");
    set_omega(1, 8'h20); cycle("bp2");
    set_omega(1, 8'h30); cycle("bp3");
    upd = '0;
    cycle("bp_hold");
    check("bp_hold_ch",    out_ch,    1);
    check("bp_hold_omega", out_omega, 8'h10);
    check("bp_ovf",        ovf[1],    1);
    out_ready = 1'b1;
    cycle("bp_acc1");
    check("bp_second", out_omega, 8'h30);
    check("bp_second_v", out_valid, 1);
    cycle("bp_acc2");
    check("bp_empty", out_valid, 0);

    // Overrun clear, then set-wins-over-clear.
    ovf_clr = 4'b0010; cycle("clr");
    check("clr_ovf", ovf[1], 0);
    ovf_clr = '0; out_ready = 1'b0; upd = 4'b0010;
    set_omega(1, 8'h41); cycle("ovr1");
    set_omega(1, 8'h42); cycle("ovr2");
    set_omega(1, 8'h43); ovf_clr = 4'b0010; cycle("ovr3");
    check("set_wins", ovf[1], 1);
    upd = '0; ovf_clr = '0; out_ready = 1'b1;
    repeat (3) cycle("ovr_drain");
    ovf_clr = '1; cycle("ovr_clr");
    ovf_clr = '0;

    // Disable a pending channel: it must never appear.
    out_ready = 1'b0;
    upd = 4'b0001; set_omega(0, 8'h55); cycle("dis_a");
    upd = 4'b1000; set_omega(3, 8'h66); cycle("dis_b");
    upd = '0; en = 4'b0111; cycle("dis_c");
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      cycle("dis_drain");
      check("dis_no_ch3", out_valid && out_ch == 3, 0);
    end
    en = '1;
    repeat (2) cycle("dis_reen");
    check("dis_reen_idle", out_valid, 0);

    // Reset mid-transfer drops everything.
    out_ready = 1'b0;
    upd = 4'b0101; set_omega(0, 8'h77); set_omega(2, 8'h88); cycle("mr_cap");
    upd = '0; cycle("mr_load");
    check("mr_loaded", out_valid, 1);
    reset = 1'b0; cycle("mr_rst");
    check("mr_valid", out_valid, 0);
    reset = 1'b1; out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      cycle("mr_after");
      check("mr_no_stale", out_valid, 0);
    end

    // Fairness with all channels continuously pending.
    upd = 4'hF; cycle("fair_cap");
    for (int n = 0; n < 2 * NCH; n++) begin
      cycle("fair");
      check("fair_ch", out_ch, n % NCH);
    end
    upd = '0;
    repeat (NCH + 1) cycle("fair_drain");
    ovf_clr = '1; cycle("fair_clr");
    ovf_clr = '0;

    // Randomized traffic against the model.
    for (int n = 0; n < 4000; n++) begin
      reset = ($urandom % 300) != 0;
      for (int i = 0; i < NCH; i++) begin
        en[i]  = ($urandom % 10) != 0;
        upd[i] = ($urandom % 3) == 0;
      end
      omega_in  = $urandom;
      cw_in     = NCH'($urandom);
      ovf_clr   = (($urandom % 5) == 0) ? NCH'($urandom) : '0;
      out_ready = ($urandom % 3) != 0;
      cycle("rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
